// File: rtl/fpu_issue_ctrl_if.sv
// Handshake bundle between the requester, the issue controller and the FPU.
// The slave modport is the controller's view; master is the surrounding environment.
interface fpu_issue_ctrl_if #(
    parameter int X_ID_WIDTH = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic [X_ID_WIDTH-1:0] in_id;
    logic                  enable;
    logic [31:0]           instruction;
    logic [X_ID_WIDTH-1:0] id;
    logic                  fpu_ready;
    logic                  wb_valid;
    logic [X_ID_WIDTH-1:0] wb_id;

    modport master (
        output in_valid, in_instr, in_id, fpu_ready, wb_valid, wb_id,
        input  in_ready, enable, instruction, id
    );

    modport slave (
        input  in_valid, in_instr, in_id, fpu_ready, wb_valid, wb_id,
        output in_ready, enable, instruction, id
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: decodes FLW/FSW/OP-FP, tracks in-flight instructions in a
// small scoreboard, blocks RAW/WAW/duplicate-ID hazards and registers the issue to the FPU.
module fpu_issue_ctrl #(
    parameter int NUM_REGS        = 32,
    parameter int PIPELINE_STAGES = 4,
    parameter int X_ID_WIDTH      = 4
) (
    input  logic                                   ck,
    input  logic                                   rst,
    fpu_issue_ctrl_if.slave                        bus,
    output logic [$clog2(PIPELINE_STAGES+1)-1:0]   inflight_cnt,
    output logic                                   illegal,
    output logic                                   wb_err
);
    localparam int CW = $clog2(PIPELINE_STAGES + 1);
    localparam int RW = $clog2(NUM_REGS);
    localparam logic [CW-1:0] MAX_CNT = CW'(PIPELINE_STAGES);

    localparam logic [6:0] OP_FLW  = 7'b0000111;
    localparam logic [6:0] OP_FSW  = 7'b0100111;
    localparam logic [6:0] OP_OPFP = 7'b1010011;

    logic [PIPELINE_STAGES-1:0] ent_valid;
    logic [PIPELINE_STAGES-1:0] ent_wfp;
    logic [X_ID_WIDTH-1:0]      ent_id [PIPELINE_STAGES];
    logic [RW-1:0]              ent_rd [PIPELINE_STAGES];

    logic                  enable_q;
    logic [31:0]           instruction_q;
    logic [X_ID_WIDTH-1:0] id_q;

    logic [6:0]    opcode;
    logic [RW-1:0] rd, rs1, rs2;
    logic          is_flw, is_fsw, is_opfp, legal;
    logic          reads_rs1, reads_rs2, writes_rd;

    assign opcode    = bus.in_instr[6:0];
    assign rd        = bus.in_instr[7 +: RW];
    assign rs1       = bus.in_instr[15 +: RW];
    assign rs2       = bus.in_instr[20 +: RW];
    assign is_flw    = (opcode == OP_FLW);
    assign is_fsw    = (opcode == OP_FSW);
    assign is_opfp   = (opcode == OP_OPFP);
    assign legal     = is_flw || is_fsw || is_opfp;
    assign reads_rs1 = is_opfp;
    assign reads_rs2 = is_fsw || is_opfp;
    assign writes_rd = is_flw || is_opfp;

    logic                       hazard;
    logic                       full;
    logic                       in_ready_c;
    logic                       accept;
    logic                       do_alloc;
    logic                       do_free;
    logic                       wb_match;
    logic                       slot_found;
    logic [PIPELINE_STAGES-1:0] alloc_oh;
    logic [PIPELINE_STAGES-1:0] free_oh;

    // All hazard/full terms look only at registered state, so a writeback
    // unblocks a dependent instruction one cycle later at the earliest.
    always_comb begin
        hazard     = 1'b0;
        alloc_oh   = '0;
        free_oh    = '0;
        slot_found = 1'b0;
        wb_match   = 1'b0;
        for (int i = 0; i < PIPELINE_STAGES; i++) begin
            if (ent_valid[i]) begin
                if (ent_id[i] == bus.in_id)
                    hazard = 1'b1;
                if (ent_wfp[i] && ((reads_rs1 && rs1 == ent_rd[i]) ||
                                   (reads_rs2 && rs2 == ent_rd[i]) ||
                                   (writes_rd && rd  == ent_rd[i])))
                    hazard = 1'b1;
                if (!wb_match && ent_id[i] == bus.wb_id) begin
                    free_oh[i] = 1'b1;
                    wb_match   = 1'b1;
                end
            end else if (!slot_found) begin
                alloc_oh[i] = 1'b1;
                slot_found  = 1'b1;
            end
        end
    end

    // Illegal opcodes are swallowed regardless of hazards or occupancy.
    assign full       = (inflight_cnt >= MAX_CNT);
    assign in_ready_c = !rst && (!enable_q || bus.fpu_ready) &&
                        (!legal || (!hazard && !full));
    assign accept     = bus.in_valid && in_ready_c;
    assign do_alloc   = accept && legal;
    assign do_free    = bus.wb_valid && wb_match;

    always_ff @(posedge ck) begin
        if (rst) begin
            ent_valid     <= '0;
            ent_wfp       <= '0;
            inflight_cnt  <= '0;
            enable_q      <= 1'b0;
            instruction_q <= '0;
            id_q          <= '0;
            illegal       <= 1'b0;
            wb_err        <= 1'b0;
        end else begin
            for (int i = 0; i < PIPELINE_STAGES; i++) begin
                if (do_alloc && alloc_oh[i]) begin
                    ent_valid[i] <= 1'b1;
                    ent_wfp[i]   <= writes_rd;
                    ent_id[i]    <= bus.in_id;
                    ent_rd[i]    <= rd;
                end else if (do_free && free_oh[i]) begin
                    ent_valid[i] <= 1'b0;
                end
            end

            case ({do_alloc, do_free})
                2'b10:   inflight_cnt <= inflight_cnt + CW'(1);
                2'b01:   inflight_cnt <= inflight_cnt - CW'(1);
                default: inflight_cnt <= inflight_cnt;
            endcase

            if (do_alloc) begin
                enable_q      <= 1'b1;
                instruction_q <= bus.in_instr;
                id_q          <= bus.in_id;
            end else if (enable_q && bus.fpu_ready) begin
                enable_q <= 1'b0;
            end

            illegal <= accept && !legal;
            wb_err  <= bus.wb_valid && !wb_match;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.enable      = enable_q;
    assign bus.instruction = instruction_q;
    assign bus.id          = id_q;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: a per-cycle vector table for the issue/hazard/full
// flows, then hand-written sequences for output hold, illegal, unknown writeback and reset.
module tb_fpu_issue_ctrl;
    localparam logic [31:0] FLW1 = 32'h0000_2087;
    localparam logic [31:0] FLW2 = 32'h0000_2107;
    localparam logic [31:0] FADD = 32'h0020_81D3;
    localparam logic [31:0] FSW3 = 32'h0030_2027;
    localparam int          NVEC = 25;

    logic       ck;
    logic       rst;
    logic [2:0] inflight_cnt;
    logic       illegal;
    logic       wb_err;
    int         n_checks;
    int         n_fails;

    fpu_issue_ctrl_if #(.X_ID_WIDTH(4)) bus ();

    fpu_issue_ctrl #(
        .NUM_REGS       (32),
        .PIPELINE_STAGES(4),
        .X_ID_WIDTH     (4)
    ) dut (
        .ck          (ck),
        .rst         (rst),
        .bus         (bus.slave),
        .inflight_cnt(inflight_cnt),
        .illegal     (illegal),
        .wb_err      (wb_err)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        logic        in_valid;
        logic [31:0] in_instr;
        logic [3:0]  in_id;
        logic        wb_valid;
        logic [3:0]  wb_id;
        logic        exp_ready;
        logic        exp_enable;
        logic [3:0]  exp_id;
        logic [2:0]  exp_cnt;
        logic        exp_illegal;
        logic        exp_wb_err;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic v, input logic [31:0] ins, input logic [3:0] iid,
                                input logic wv, input logic [3:0] wid,
                                input logic er, input logic ee, input logic [3:0] eid,
                                input logic [2:0] ec, input logic ei, input logic ew);
        vec_t r;
        r.in_valid    = v;
        r.in_instr    = ins;
        r.in_id       = iid;
        r.wb_valid    = wv;
        r.wb_id       = wid;
        r.exp_ready   = er;
        r.exp_enable  = ee;
        r.exp_id      = eid;
        r.exp_cnt     = ec;
        r.exp_illegal = ei;
        r.exp_wb_err  = ew;
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle's inputs mid-period and let combinational outputs settle.
    task automatic apply_stimulus(input logic r, input logic v, input logic [31:0] ins,
                                  input logic [3:0] iid, input logic fr,
                                  input logic wv, input logic [3:0] wid);
        @(negedge ck);
        rst           = r;
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_id     = iid;
        bus.fpu_ready = fr;
        bus.wb_valid  = wv;
        bus.wb_id     = wid;
        #1;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;

        vecs[0]  = mk(1, FLW1, 1, 0, 0,  1, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, FLW2, 2, 0, 0,  1, 1, 1, 1, 0, 0);
        vecs[2]  = mk(1, FADD, 3, 0, 0,  0, 1, 2, 2, 0, 0);
        vecs[3]  = mk(1, FADD, 3, 1, 1,  0, 0, 2, 2, 0, 0);
        vecs[4]  = mk(1, FADD, 3, 1, 2,  0, 0, 2, 1, 0, 0);
        vecs[5]  = mk(1, FADD, 3, 0, 0,  1, 0, 2, 0, 0, 0);
        vecs[6]  = mk(1, FSW3, 4, 0, 0,  0, 1, 3, 1, 0, 0);
        vecs[7]  = mk(1, FSW3, 4, 1, 3,  0, 0, 3, 1, 0, 0);
        vecs[8]  = mk(1, FSW3, 4, 0, 0,  1, 0, 3, 0, 0, 0);
        vecs[9]  = mk(0, 32'h0, 0, 0, 0, 1, 1, 4, 1, 0, 0);
        vecs[10] = mk(0, 32'h0, 0, 1, 4, 1, 0, 4, 1, 0, 0);
        vecs[11] = mk(0, 32'h0, 0, 0, 0, 1, 0, 4, 0, 0, 0);
        vecs[12] = mk(1, 32'h0000_2207, 5, 0, 0, 1, 0, 4, 0, 0, 0);
        vecs[13] = mk(1, 32'h0000_2287, 6, 0, 0, 1, 1, 5, 1, 0, 0);
        vecs[14] = mk(1, 32'h0000_2307, 7, 0, 0, 1, 1, 6, 2, 0, 0);
        vecs[15] = mk(1, 32'h0000_2387, 8, 0, 0, 1, 1, 7, 3, 0, 0);
        vecs[16] = mk(1, 32'h0000_2407, 9, 0, 0, 0, 1, 8, 4, 0, 0);
        vecs[17] = mk(1, 32'h0000_2407, 9, 1, 5, 0, 0, 8, 4, 0, 0);
        vecs[18] = mk(1, 32'h0000_2407, 9, 0, 0, 1, 0, 8, 3, 0, 0);
        vecs[19] = mk(0, 32'h0, 0, 0, 0, 1, 1, 9, 4, 0, 0);
        vecs[20] = mk(0, 32'h0, 0, 1, 6, 1, 0, 9, 4, 0, 0);
        vecs[21] = mk(0, 32'h0, 0, 1, 7, 1, 0, 9, 3, 0, 0);
        vecs[22] = mk(0, 32'h0, 0, 1, 8, 1, 0, 9, 2, 0, 0);
        vecs[23] = mk(0, 32'h0, 0, 1, 9, 1, 0, 9, 1, 0, 0);
        vecs[24] = mk(0, 32'h0, 0, 0, 0, 1, 0, 9, 0, 0, 0);

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus.in_id     = 4'h0;
        bus.fpu_ready = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.wb_id     = 4'h0;

        apply_stimulus(1'b1, 1'b1, FLW1, 4'h1, 1'b1, 1'b0, 4'h0);
        check_output("reset.in_ready_a", {31'h0, bus.in_ready}, 32'h0);
        apply_stimulus(1'b1, 1'b1, FLW1, 4'h1, 1'b1, 1'b0, 4'h0);
        check_output("reset.in_ready_b", {31'h0, bus.in_ready}, 32'h0);
        check_output("reset.instruction", bus.instruction, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(1'b0, vecs[i].in_valid, vecs[i].in_instr, vecs[i].in_id, 1'b1,
                           vecs[i].wb_valid, vecs[i].wb_id);
            check_output($sformatf("row%0d.in_ready", i), {31'h0, bus.in_ready},
                         {31'h0, vecs[i].exp_ready});
            check_output($sformatf("row%0d.enable", i), {31'h0, bus.enable},
                         {31'h0, vecs[i].exp_enable});
            check_output($sformatf("row%0d.id", i), {28'h0, bus.id}, {28'h0, vecs[i].exp_id});
            check_output($sformatf("row%0d.inflight_cnt", i), {29'h0, inflight_cnt},
                         {29'h0, vecs[i].exp_cnt});
            check_output($sformatf("row%0d.illegal", i), {31'h0, illegal},
                         {31'h0, vecs[i].exp_illegal});
            check_output($sformatf("row%0d.wb_err", i), {31'h0, wb_err},
                         {31'h0, vecs[i].exp_wb_err});
        end

        // FPU back-pressure: the presented instruction must not move while stalled.
        apply_stimulus(1'b0, 1'b1, FLW1, 4'h1, 1'b0, 1'b0, 4'h0);
        check_output("hold.accept_first", {31'h0, bus.in_ready}, 32'h1);
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(1'b0, 1'b1, FLW2, 4'h2, 1'b0, 1'b0, 4'h0);
            check_output($sformatf("hold%0d.in_ready", c), {31'h0, bus.in_ready}, 32'h0);
            check_output($sformatf("hold%0d.enable", c), {31'h0, bus.enable}, 32'h1);
            check_output($sformatf("hold%0d.id", c), {28'h0, bus.id}, 32'h1);
            check_output($sformatf("hold%0d.instruction", c), bus.instruction, FLW1);
        end
        apply_stimulus(1'b0, 1'b1, FLW2, 4'h2, 1'b1, 1'b0, 4'h0);
        check_output("hold.release_ready", {31'h0, bus.in_ready}, 32'h1);
        idle();
        check_output("hold.b2b_enable", {31'h0, bus.enable}, 32'h1);
        check_output("hold.b2b_id", {28'h0, bus.id}, 32'h2);
        check_output("hold.b2b_instruction", bus.instruction, FLW2);
        check_output("hold.cnt", {29'h0, inflight_cnt}, 32'h2);
        apply_stimulus(1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 4'h1);
        check_output("hold.enable_clear", {31'h0, bus.enable}, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 4'h2);
        idle();
        check_output("hold.drained", {29'h0, inflight_cnt}, 32'h0);

        // Unsupported opcode: accepted, dropped, one illegal pulse.
        apply_stimulus(1'b0, 1'b1, 32'h0000_007F, 4'hA, 1'b1, 1'b0, 4'h0);
        check_output("illegal.in_ready", {31'h0, bus.in_ready}, 32'h1);
        check_output("illegal.before", {31'h0, illegal}, 32'h0);
        idle();
        check_output("illegal.pulse", {31'h0, illegal}, 32'h1);
        check_output("illegal.no_issue", {31'h0, bus.enable}, 32'h0);
        check_output("illegal.no_entry", {29'h0, inflight_cnt}, 32'h0);
        idle();
        check_output("illegal.once", {31'h0, illegal}, 32'h0);

        // Writeback for an ID nobody holds.
        apply_stimulus(1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 4'hF);
        check_output("wb_err.before", {31'h0, wb_err}, 32'h0);
        idle();
        check_output("wb_err.pulse", {31'h0, wb_err}, 32'h1);
        check_output("wb_err.cnt", {29'h0, inflight_cnt}, 32'h0);
        idle();
        check_output("wb_err.once", {31'h0, wb_err}, 32'h0);

        // Reset with two entries in flight and a stalled issue.
        apply_stimulus(1'b0, 1'b1, FLW1, 4'h1, 1'b1, 1'b0, 4'h0);
        apply_stimulus(1'b0, 1'b1, FLW2, 4'h2, 1'b1, 1'b0, 4'h0);
        apply_stimulus(1'b0, 1'b1, FADD, 4'h3, 1'b0, 1'b0, 4'h0);
        check_output("rst.pre_enable", {31'h0, bus.enable}, 32'h1);
        check_output("rst.pre_cnt", {29'h0, inflight_cnt}, 32'h2);
        check_output("rst.pre_hazard", {31'h0, bus.in_ready}, 32'h0);
        apply_stimulus(1'b1, 1'b1, FADD, 4'h3, 1'b1, 1'b1, 4'hF);
        check_output("rst.in_ready_low", {31'h0, bus.in_ready}, 32'h0);
        apply_stimulus(1'b0, 1'b1, FADD, 4'h3, 1'b1, 1'b0, 4'h0);
        check_output("rst.enable", {31'h0, bus.enable}, 32'h0);
        check_output("rst.cnt", {29'h0, inflight_cnt}, 32'h0);
        check_output("rst.id", {28'h0, bus.id}, 32'h0);
        check_output("rst.instruction", bus.instruction, 32'h0);
        check_output("rst.wb_err", {31'h0, wb_err}, 32'h0);
        check_output("rst.accept_after", {31'h0, bus.in_ready}, 32'h1);
        idle();
        check_output("rst.issue_enable", {31'h0, bus.enable}, 32'h1);
        check_output("rst.issue_id", {28'h0, bus.id}, 32'h3);
        check_output("rst.issue_instruction", bus.instruction, FADD);
        check_output("rst.issue_cnt", {29'h0, inflight_cnt}, 32'h1);
        apply_stimulus(1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 4'h3);
        idle();
        check_output("rst.final_cnt", {29'h0, inflight_cnt}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
